// File: rtl/flag_byte_scrambler_if.sv
// rtl/flag_byte_scrambler_if.sv - byte stream bundle between the scrambler and its neighbours
interface flag_byte_scrambler_if;
    logic [7:0] inp;
    logic [7:0] res;

    // Upstream source drives plaintext and observes the scrambled byte
    modport master (
        output inp,
        input  res
    );

    // Scrambler samples plaintext and drives the scrambled byte
    modport slave (
        input  inp,
        output res
    );
endinterface

// File: rtl/flag_byte_scrambler.sv
// rtl/flag_byte_scrambler.sv - keyed byte-serial scrambler with four rotating rounds
module flag_byte_scrambler #(
    parameter logic [7:0] KEY_INIT = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    flag_byte_scrambler_if.slave  chall_bus
);

    localparam logic [1:0] ROUND_XOR = 2'd0;
    localparam logic [1:0] ROUND_ADD = 2'd1;
    localparam logic [1:0] ROUND_NOT = 2'd2;
    localparam logic [1:0] ROUND_SUB = 2'd3;

    logic [7:0] res_q, res_d;
    logic [7:0] key_q, key_d;
    logic [1:0] st_q,  st_d;
    logic [7:0] t;
    logic [7:0] rotl3_inp;
    logic [7:0] rotr2_inp;

    assign rotl3_inp = {chall_bus.inp[4:0], chall_bus.inp[7:5]};
    assign rotr2_inp = {chall_bus.inp[1:0], chall_bus.inp[7:2]};

    // Round function: one of four byte transforms selected by the round counter
    always_comb begin
        t = 8'h00;
        case (st_q)
            ROUND_XOR: t = rotl3_inp ^ key_q;
            ROUND_ADD: t = chall_bus.inp + key_q;
            ROUND_NOT: t = (~chall_bus.inp) ^ key_q;
            ROUND_SUB: t = rotr2_inp - key_q;
            default:   t = 8'h00;
        endcase
    end

    // Next state: output and key both take the round result, counter wraps naturally
    always_comb begin
        res_d = t;
        key_d = t;
        st_d  = st_q + 2'd1;
    end

    // State update; reset discards any in-flight key chain and restarts at round 0
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= 8'h00;
            key_q <= KEY_INIT;
            st_q  <= ROUND_XOR;
        end else begin
            res_q <= res_d;
            key_q <= key_d;
            st_q  <= st_d;
        end
    end

    assign chall_bus.res = res_q;

endmodule

// File: tb/tb_flag_byte_scrambler.sv
// tb/tb_flag_byte_scrambler.sv - directed and reference-model bench for flag_byte_scrambler
module tb_flag_byte_scrambler;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    // Reference model state for the KEY_INIT=0 instance and for the long stream
    logic [7:0] mkey_a, mkey_b;
    logic [1:0] mst_a,  mst_b;

    flag_byte_scrambler_if bus_a ();
    flag_byte_scrambler_if bus_b ();

    flag_byte_scrambler chall (
        .clk       (clk),
        .rst       (rst),
        .chall_bus (bus_a.slave)
    );

    flag_byte_scrambler #(.KEY_INIT(8'h00)) chall_k0 (
        .clk       (clk),
        .rst       (rst),
        .chall_bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_round(input logic [7:0] d, input logic [1:0] s,
                                             input logic [7:0] k);
        logic [15:0] dd;
        dd = {d, d};
        case (s)
            2'd0: return dd[12:5] ^ k;
            2'd1: return 8'((9'(d) + 9'(k)) & 9'h0FF);
            2'd2: return 8'hFF ^ d ^ k;
            default: return 8'((9'h100 + 9'(dd[9:2]) - 9'(k)) & 9'h0FF);
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (q_a.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s_a scoreboard empty observed=%02h expected=none", tag, bus_a.res);
        end else begin
            e = q_a.pop_front();
            check({tag, "_a"}, bus_a.res, e);
        end
        if (q_b.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s_b scoreboard empty observed=%02h expected=none", tag, bus_b.res);
        end else begin
            e = q_b.pop_front();
            check({tag, "_b"}, bus_b.res, e);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus_a.inp = 8'hxx;
        bus_b.inp = 8'hxx;
        q_a.push_back(8'h00);
        q_b.push_back(8'h00);
        mkey_a = 8'hA5; mst_a = 2'd0;
        mkey_b = 8'h00; mst_b = 2'd0;
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    // exp_a is a directed constant; the KEY_INIT=0 instance always follows the model
    task automatic step(input string tag, input logic [7:0] d, input logic [7:0] exp_a);
        logic [7:0] tb_b;
        rst = 1'b0;
        bus_a.inp = d;
        bus_b.inp = d;
        mkey_a = ref_round(d, mst_a, mkey_a); mst_a = mst_a + 2'd1;
        tb_b   = ref_round(d, mst_b, mkey_b);
        mkey_b = tb_b; mst_b = mst_b + 2'd1;
        q_a.push_back(exp_a);
        q_b.push_back(tb_b);
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    initial begin
        logic [7:0] seq_in [5];
        logic [7:0] seq_ex [5];
        logic [7:0] zer_ex [5];
        logic [7:0] d;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_a.inp = 8'h00;
        bus_b.inp = 8'h00;
        seq_in = '{8'h66, 8'h6C, 8'h61, 8'h67, 8'h7B};
        seq_ex = '{8'h96, 8'h02, 8'h9C, 8'h3D, 8'hE6};
        zer_ex = '{8'hA5, 8'hA5, 8'h5A, 8'hA6, 8'hA6};
        #2;

        for (int i = 0; i < 3; i++) do_reset("reset_hold");

        for (int i = 0; i < 5; i++) begin
            step("flag_seq", seq_in[i], seq_ex[i]);
            if (i == 0) check("key0_override", bus_b.res, 8'h33);
        end

        do_reset("reset_zero");
        for (int i = 0; i < 5; i++) step("zero_seq", 8'h00, zer_ex[i]);

        do_reset("reset_mid_pre");
        step("mid_a", 8'h66, 8'h96);
        step("mid_b", 8'h6C, 8'h02);
        do_reset("reset_mid");
        step("mid_after", 8'h66, 8'h96);

        do_reset("reset_long");
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            d = 8'($urandom_range(0, 255));
            e = ref_round(d, mst_a, mkey_a);
            step("long", d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
